aes128_axil_regs: RTL and testbench

AES128_AXIL_REGS -- requirements
Module: aes128_axil_regs

---
 rtl/aes128_axil_regs.sv | 206 ++++++++++++++++++++
 tb/tb_aes128_axil_regs.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit R/W registers that form the 128-bit word fed to the AES core.
// Word indices 4..7 are unmapped and answer SLVERR.
module aes128_axil_regs #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                              ACLK,
  input  logic                              ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   reg_out
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = C_S_AXI_DATA_WIDTH / 8;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {WIdle, WHaveAddr, WHaveData, WResp} w_state_e;
  typedef enum logic {RIdle, RResp} r_state_e;

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic [3:0][DW-1:0] slv_reg_q, slv_reg_d;
  logic [2:0]         waddr_q, waddr_d;
  logic [DW-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]      wstrb_q, wstrb_d;
  logic               awready_q, awready_d;
  logic               wready_q, wready_d;
  logic               bvalid_q, bvalid_d;
  logic [1:0]         bresp_q, bresp_d;
  logic               arready_q, arready_d;
  logic               rvalid_q, rvalid_d;
  logic [1:0]         rresp_q, rresp_d;
  logic [DW-1:0]      rdata_q, rdata_d;

  logic          aw_hs, w_hs, ar_hs;
  logic          commit;
  logic [2:0]    cidx;
  logic [DW-1:0] cdata;
  logic [SW-1:0] cstrb;
  logic [2:0]    ar_idx;

  // Protection bits and byte-offset bits carry no meaning for this block.
  logic unused_in;
  assign unused_in = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign aw_hs  = S_AXI_AWVALID & awready_q;
  assign w_hs   = S_AXI_WVALID & wready_q;
  assign ar_hs  = S_AXI_ARVALID & arready_q;
  assign ar_idx = S_AXI_ARADDR[4:2];

  // Write FSM: collect AW and W in either order, commit on the completing edge, then respond.
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit    = 1'b0;
    cidx      = waddr_q;
    cdata     = wdata_q;
    cstrb     = wstrb_q;
    case (w_state_q)
      WIdle: begin
        if (aw_hs && w_hs) begin
          commit    = 1'b1;
          cidx      = S_AXI_AWADDR[4:2];
          cdata     = S_AXI_WDATA;
          cstrb     = S_AXI_WSTRB;
          w_state_d = WResp;
        end else if (aw_hs) begin
          waddr_d   = S_AXI_AWADDR[4:2];
          w_state_d = WHaveAddr;
        end else if (w_hs) begin
          wdata_d   = S_AXI_WDATA;
          wstrb_d   = S_AXI_WSTRB;
          w_state_d = WHaveData;
        end
      end
      WHaveAddr: begin
        if (w_hs) begin
          commit    = 1'b1;
          cidx      = waddr_q;
          cdata     = S_AXI_WDATA;
          cstrb     = S_AXI_WSTRB;
          w_state_d = WResp;
        end
      end
      WHaveData: begin
        if (aw_hs) begin
          commit    = 1'b1;
          cidx      = S_AXI_AWADDR[4:2];
          cdata     = wdata_q;
          cstrb     = wstrb_q;
          w_state_d = WResp;
        end
      end
      WResp: begin
        if (bvalid_q && S_AXI_BREADY) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
    // Ready/valid flags are registered images of the next state.
    awready_d = (w_state_d == WIdle) || (w_state_d == WHaveData);
    wready_d  = (w_state_d == WIdle) || (w_state_d == WHaveAddr);
    bvalid_d  = (w_state_d == WResp);
    bresp_d   = bresp_q;
    if (commit) bresp_d = cidx[2] ? RespSlvErr : RespOkay;
  end

  // Byte-lane merge of the committed write into the register file; unmapped indices are dropped.
  always_comb begin
    slv_reg_d = slv_reg_q;
    if (commit && !cidx[2]) begin
      for (int i = 0; i < int'(SW); i++) begin
        if (cstrb[i]) slv_reg_d[cidx[1:0]][8*i +: 8] = cdata[8*i +: 8];
      end
    end
  end

  // Read FSM: capture from the pre-commit register value, hold until RREADY.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      RIdle: begin
        if (ar_hs) begin
          r_state_d = RResp;
          rdata_d   = ar_idx[2] ? '0 : slv_reg_q[ar_idx[1:0]];
          rresp_d   = ar_idx[2] ? RespSlvErr : RespOkay;
        end
      end
      RResp: begin
        if (rvalid_q && S_AXI_RREADY) r_state_d = RIdle;
      end
      default: r_state_d = RIdle;
    endcase
    arready_d = (r_state_d == RIdle);
    rvalid_d  = (r_state_d == RResp);
  end

  // State and register file; reset abandons any in-flight transaction.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= WIdle;
      r_state_q <= RIdle;
      slv_reg_q <= '0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RespOkay;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RespOkay;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      slv_reg_q <= slv_reg_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RDATA   = rdata_q;
  assign reg_out       = slv_reg_q;

endmodule

// File: tb/tb_aes128_axil_regs.sv
// Directed bench for aes128_axil_regs: inputs change on the falling edge, outputs checked there too.
module tb_aes128_axil_regs;

  logic         ACLK;
  logic         ARESETN;
  logic [4:0]   AWADDR;
  logic [2:0]   AWPROT;
  logic         AWVALID;
  logic         AWREADY;
  logic [31:0]  WDATA;
  logic [3:0]   WSTRB;
  logic         WVALID;
  logic         WREADY;
  logic [1:0]   BRESP;
  logic         BVALID;
  logic         BREADY;
  logic [4:0]   ARADDR;
  logic [2:0]   ARPROT;
  logic         ARVALID;
  logic         ARREADY;
  logic [31:0]  RDATA;
  logic [1:0]   RRESP;
  logic         RVALID;
  logic         RREADY;
  logic [127:0] reg_out;

  int checks = 0;
  int errors = 0;

  aes128_axil_regs #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .S_AXI_AWADDR (AWADDR),
    .S_AXI_AWPROT (AWPROT),
    .S_AXI_AWVALID(AWVALID),
    .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA  (WDATA),
    .S_AXI_WSTRB  (WSTRB),
    .S_AXI_WVALID (WVALID),
    .S_AXI_WREADY (WREADY),
    .S_AXI_BRESP  (BRESP),
    .S_AXI_BVALID (BVALID),
    .S_AXI_BREADY (BREADY),
    .S_AXI_ARADDR (ARADDR),
    .S_AXI_ARPROT (ARPROT),
    .S_AXI_ARVALID(ARVALID),
    .S_AXI_ARREADY(ARREADY),
    .S_AXI_RDATA  (RDATA),
    .S_AXI_RRESP  (RRESP),
    .S_AXI_RVALID (RVALID),
    .S_AXI_RREADY (RREADY),
    .reg_out      (reg_out)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // AW and W together; entered and left on a falling edge.
  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] resp);
    chk("wr_awready", AWREADY, 1);
    chk("wr_wready", WREADY, 1);
    AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    chk("wr_bvalid", BVALID, 1);
    chk("wr_bresp", BRESP, resp);
    chk("wr_awready_busy", AWREADY, 0);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("wr_bvalid_done", BVALID, 0);
    chk("wr_awready_back", AWREADY, 1);
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] d, input logic [1:0] resp);
    chk("rd_arready", ARREADY, 1);
    ARADDR = a; ARVALID = 1'b1;
    @(negedge ACLK);
    ARVALID = 1'b0;
    chk("rd_rvalid", RVALID, 1);
    chk("rd_rdata", RDATA, d);
    chk("rd_rresp", RRESP, resp);
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    chk("rd_rvalid_done", RVALID, 0);
    chk("rd_arready_back", ARREADY, 1);
  endtask

  initial begin
    AWADDR = '0; AWPROT = '0; AWVALID = 0; WDATA = '0; WSTRB = '0; WVALID = 0; BREADY = 0;
    ARADDR = '0; ARPROT = '0; ARVALID = 0; RREADY = 0;
    ARESETN = 1'b1;
    #1 ARESETN = 1'b0;
    repeat (2) @(negedge ACLK);

    // Reset state
    chk("rst_awready", AWREADY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_arready", ARREADY, 0);
    chk("rst_bvalid", BVALID, 0);
    chk("rst_rvalid", RVALID, 0);
    chk("rst_bresp", BRESP, 0);
    chk("rst_rresp", RRESP, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_reg_out", reg_out, 0);
    ARESETN = 1'b1;
    #1 chk("rel_awready_before_edge", AWREADY, 0);
    @(negedge ACLK);
    chk("rel_awready", AWREADY, 1);
    chk("rel_wready", WREADY, 1);
    chk("rel_arready", ARREADY, 1);

    // Four mapped writes and readbacks
    wr(5'h00, 32'd1, 4'hF, 2'b00);
    wr(5'h04, 32'd2, 4'hF, 2'b00);
    wr(5'h08, 32'd3, 4'hF, 2'b00);
    wr(5'h0C, 32'd4, 4'hF, 2'b00);
    rd(5'h00, 32'd1, 2'b00);
    rd(5'h04, 32'd2, 2'b00);
    rd(5'h08, 32'd3, 2'b00);
    rd(5'h0C, 32'd4, 2'b00);
    chk("reg_out_1234", reg_out, 128'h00000004_00000003_00000002_00000001);

    // W leads AW by three cycles
    WDATA = 32'hAABBCCDD; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("wfirst_wready", WREADY, 0);
    chk("wfirst_awready", AWREADY, 1);
    chk("wfirst_bvalid", BVALID, 0);
    repeat (2) @(negedge ACLK);
    chk("wfirst_no_commit", reg_out[95:64], 32'd3);
    AWADDR = 5'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("wfirst_bvalid_after", BVALID, 1);
    chk("wfirst_reg2", reg_out[95:64], 32'hAABBCCDD);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("wfirst_done", BVALID, 0);

    // Byte strobes
    wr(5'h04, 32'h11223344, 4'hF, 2'b00);
    wr(5'h04, 32'hFFFFFFFF, 4'b0101, 2'b00);
    rd(5'h04, 32'h11FF33FF, 2'b00);
    wr(5'h04, 32'h00000000, 4'b0000, 2'b00);
    rd(5'h04, 32'h11FF33FF, 2'b00);

    // Unmapped address; byte-offset bits ignored
    wr(5'h14, 32'hDEADBEEF, 4'hF, 2'b10);
    rd(5'h14, 32'h0, 2'b10);
    chk("unmapped_regs", reg_out, 128'h00000004_AABBCCDD_11FF33FF_00000001);
    rd(5'h0B, 32'hAABBCCDD, 2'b00);

    // Concurrent write and read of reg0 with responses stalled for 10 cycles
    AWADDR = 5'h00; AWVALID = 1'b1; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; WVALID = 1'b1;
    ARADDR = 5'h00; ARVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stall_bvalid", BVALID, 1);
      chk("stall_bresp", BRESP, 0);
      chk("stall_rvalid", RVALID, 1);
      chk("stall_rdata_prewrite", RDATA, 32'd1);
      chk("stall_rresp", RRESP, 0);
      chk("stall_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
      @(negedge ACLK);
    end
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    chk("stall_released_valids", {BVALID, RVALID}, 2'b00);
    chk("stall_released_readys", {AWREADY, WREADY, ARREADY}, 3'b111);
    rd(5'h00, 32'hCAFEF00D, 2'b00);

    // AW leads W
    AWADDR = 5'h0C; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("awfirst_readys", {AWREADY, WREADY}, 2'b01);
    chk("awfirst_bvalid", BVALID, 0);
    WDATA = 32'h55667788; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("awfirst_bvalid_after", BVALID, 1);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("awfirst_reg_out", reg_out, 128'h55667788_AABBCCDD_11FF33FF_CAFEF00D);

    // Reset while holding an address
    AWADDR = 5'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("midrst_have_addr", {AWREADY, WREADY}, 2'b01);
    ARESETN = 1'b0;
    #1;
    chk("midrst_readys", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("midrst_valids", {BVALID, RVALID}, 2'b00);
    chk("midrst_reg_out", reg_out, 0);
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("midrst_readys_back", {AWREADY, WREADY, ARREADY}, 3'b111);
    chk("midrst_no_resp", BVALID, 0);
    // Stale address must not be used: a lone W waits for a new AW
    WDATA = 32'h00000099; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    WVALID = 1'b0;
    chk("midrst_w_waits", {BVALID, AWREADY, WREADY}, 3'b010);
    AWADDR = 5'h08; AWVALID = 1'b1;
    @(negedge ACLK);
    AWVALID = 1'b0;
    chk("midrst_commit", BVALID, 1);
    BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    chk("midrst_reg_out_final", reg_out, 128'h00000000_00000099_00000000_00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
